// File: rtl/multi_lane_pixel_streamer.sv
// multi_lane_pixel_streamer: merges N_LANES per-lane shade FIFOs back into
// raster order and drives one ready/valid pixel stream with sof/eol framing.
// Optional build macro STREAMER_STATS_EN adds frame_count / stall_count outputs.
`ifndef COLOR_WIDTH
`define COLOR_WIDTH 8
`endif

module multi_lane_pixel_streamer #(
  parameter int N_LANES    = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int COLOR_W    = `COLOR_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       frame_restart,
  input  logic [N_LANES*COLOR_W-1:0] lane_shade_in,
  input  logic [N_LANES-1:0]         lane_valid_in,
  output logic [N_LANES-1:0]         lane_ready_out,
  input  logic                       ready_in,
  output logic [COLOR_W-1:0]         shade_out,
  output logic                       valid_out,
  output logic                       sof,
  output logic                       eol
`ifdef STREAMER_STATS_EN
  ,
  output logic [15:0]                frame_count,
  output logic [31:0]                stall_count
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int LW = (N_LANES > 1) ? $clog2(N_LANES) : 1;
  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;

  // The frame must end on the last lane so the next frame restarts on lane 0.
  if ((H_RES * V_RES) % N_LANES != 0) begin : g_lane_map_check
    $error("H_RES*V_RES must be a multiple of N_LANES");
  end

  logic [COLOR_W-1:0] mem_q [N_LANES][FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_q [N_LANES];
  logic [AW-1:0]      wr_ptr_d [N_LANES];
  logic [AW-1:0]      rd_ptr_q [N_LANES];
  logic [AW-1:0]      rd_ptr_d [N_LANES];
  logic [CW-1:0]      count_q  [N_LANES];
  logic [CW-1:0]      count_d  [N_LANES];
  logic [N_LANES-1:0] ready_q, ready_d;
  logic [N_LANES-1:0] wr_en, rd_en;

  logic [LW-1:0]      rr_q, rr_d;
  logic [XW-1:0]      x_q, x_d;
  logic [YW-1:0]      y_q, y_d;
  logic [COLOR_W-1:0] shade_q, shade_d;
  logic               valid_q, valid_d;
  logic               sof_q, sof_d;
  logic               eol_q, eol_d;

  logic [COLOR_W-1:0] rd_data;
  logic               load;

  assign rd_data = mem_q[rr_q][rd_ptr_q[rr_q]];
  // Strict raster order: only the selected lane may feed the output register.
  assign load    = !frame_restart && (!valid_q || ready_in) && (count_q[rr_q] != '0);

  // Per-lane FIFO pointer/occupancy update; ready follows next occupancy.
  always_comb begin
    wr_en = '0;
    rd_en = '0;
    for (int k = 0; k < N_LANES; k++) begin
      wr_en[k]    = lane_valid_in[k] && ready_q[k] && !frame_restart;
      rd_en[k]    = load && (rr_q == LW'(k));
      wr_ptr_d[k] = wr_ptr_q[k];
      rd_ptr_d[k] = rd_ptr_q[k];
      count_d[k]  = count_q[k];
      if (frame_restart) begin
        wr_ptr_d[k] = '0;
        rd_ptr_d[k] = '0;
        count_d[k]  = '0;
      end else begin
        if (wr_en[k]) wr_ptr_d[k] = wr_ptr_q[k] + 1'b1;
        if (rd_en[k]) rd_ptr_d[k] = rd_ptr_q[k] + 1'b1;
        count_d[k] = count_q[k] + CW'(wr_en[k]) - CW'(rd_en[k]);
      end
      ready_d[k] = (count_d[k] != CW'(FIFO_DEPTH));
    end
  end

  // Output register, raster position and lane pointer.
  always_comb begin
    rr_d    = rr_q;
    x_d     = x_q;
    y_d     = y_q;
    shade_d = shade_q;
    valid_d = valid_q;
    sof_d   = sof_q;
    eol_d   = eol_q;
    if (frame_restart) begin
      rr_d    = '0;
      x_d     = '0;
      y_d     = '0;
      shade_d = '0;
      valid_d = 1'b0;
      sof_d   = 1'b0;
      eol_d   = 1'b0;
    end else if (load) begin
      shade_d = rd_data;
      valid_d = 1'b1;
      sof_d   = (x_q == '0) && (y_q == '0);
      eol_d   = (x_q == XW'(H_RES - 1));
      rr_d    = (rr_q == LW'(N_LANES - 1)) ? '0 : rr_q + 1'b1;
      if (x_q == XW'(H_RES - 1)) begin
        x_d = '0;
        y_d = (y_q == YW'(V_RES - 1)) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end else if (ready_in) begin
      valid_d = 1'b0;
    end
  end

  // FIFO storage has no reset; occupancy alone defines what is readable.
  always_ff @(posedge clk) begin
    for (int k = 0; k < N_LANES; k++) begin
      if (wr_en[k]) mem_q[k][wr_ptr_q[k]] <= lane_shade_in[k*COLOR_W +: COLOR_W];
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_LANES; k++) begin
        wr_ptr_q[k] <= '0;
        rd_ptr_q[k] <= '0;
        count_q[k]  <= '0;
      end
      ready_q <= '1;
      rr_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      shade_q <= '0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
    end else begin
      for (int k = 0; k < N_LANES; k++) begin
        wr_ptr_q[k] <= wr_ptr_d[k];
        rd_ptr_q[k] <= rd_ptr_d[k];
        count_q[k]  <= count_d[k];
      end
      ready_q <= ready_d;
      rr_q    <= rr_d;
      x_q     <= x_d;
      y_q     <= y_d;
      shade_q <= shade_d;
      valid_q <= valid_d;
      sof_q   <= sof_d;
      eol_q   <= eol_d;
    end
  end

  assign lane_ready_out = ready_q;
  assign shade_out      = shade_q;
  assign valid_out      = valid_q;
  assign sof            = sof_q;
  assign eol            = eol_q;

`ifdef STREAMER_STATS_EN
  logic        eof_q, eof_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic [31:0] stall_count_q, stall_count_d;

  // eof marks the registered pixel as the last of its frame.
  always_comb begin
    eof_d         = eof_q;
    frame_count_d = frame_count_q;
    stall_count_d = stall_count_q;
    if (frame_restart) eof_d = 1'b0;
    else if (load) eof_d = (x_q == XW'(H_RES - 1)) && (y_q == YW'(V_RES - 1));
    if (valid_q && ready_in && eof_q) frame_count_d = frame_count_q + 16'd1;
    if (frame_restart) stall_count_d = '0;
    else if (valid_q && !ready_in && !(&stall_count_q)) stall_count_d = stall_count_q + 32'd1;
  end

  // Statistics registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eof_q         <= 1'b0;
      frame_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      eof_q         <= eof_d;
      frame_count_q <= frame_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign frame_count = frame_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_multi_lane_pixel_streamer.sv
// Scoreboard bench for multi_lane_pixel_streamer (2 lanes, 4x2 frame, depth 4).
module tb_multi_lane_pixel_streamer;
  localparam int NL = 2;
  localparam int H  = 4;
  localparam int V  = 2;
  localparam int D  = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          frame_restart;
  logic [NL*CW-1:0] lane_shade_in;
  logic [NL-1:0] lane_valid_in;
  logic [NL-1:0] lane_ready_out;
  logic          ready_in;
  logic [CW-1:0] shade_out;
  logic          valid_out, sof, eol;
`ifdef STREAMER_STATS_EN
  logic [15:0]   frame_count;
  logic [31:0]   stall_count;
`endif

  multi_lane_pixel_streamer #(
    .N_LANES(NL), .FIFO_DEPTH(D), .H_RES(H), .V_RES(V), .COLOR_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .frame_restart(frame_restart),
    .lane_shade_in(lane_shade_in), .lane_valid_in(lane_valid_in),
    .lane_ready_out(lane_ready_out), .ready_in(ready_in),
    .shade_out(shade_out), .valid_out(valid_out), .sof(sof), .eol(eol)
`ifdef STREAMER_STATS_EN
    , .frame_count(frame_count), .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CW-1:0] shade;
    logic          sof;
    logic          eol;
  } exp_t;

  int   total = 0;
  int   bad = 0;
  int   n_out = 0;
  int   pix_idx = 0;
  exp_t exp_q[$];
  logic [CW-1:0] lq0[$];
  logic [CW-1:0] lq1[$];
  logic hold0 = 1'b0;

  logic          prev_stall = 1'b0;
  logic [CW-1:0] prev_shade;
  logic          prev_sof, prev_eol;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Expected framing comes from the bench's own raster index within an 8-pixel frame.
  task automatic push_pix(input logic [CW-1:0] v);
    exp_t e;
    e.shade = v;
    e.sof   = (pix_idx == 0);
    e.eol   = ((pix_idx % H) == H - 1);
    exp_q.push_back(e);
    if ((pix_idx % NL) == 0) lq0.push_back(v);
    else lq1.push_back(v);
    pix_idx = (pix_idx + 1) % (H * V);
  endtask

  // One clock of lane driving; called at posedge+1, returns at the next posedge+1.
  task automatic cycle();
    logic acc0, acc1;
    lane_valid_in[0]    = (lq0.size() > 0) && !hold0;
    lane_shade_in[7:0]  = (lq0.size() > 0) ? lq0[0] : 8'h00;
    lane_valid_in[1]    = (lq1.size() > 0);
    lane_shade_in[15:8] = (lq1.size() > 0) ? lq1[0] : 8'h00;
    @(negedge clk);
    acc0 = lane_valid_in[0] && lane_ready_out[0] && !frame_restart;
    acc1 = lane_valid_in[1] && lane_ready_out[1] && !frame_restart;
    @(posedge clk);
    #1;
    if (acc0) void'(lq0.pop_front());
    if (acc1) void'(lq1.pop_front());
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      cycle();
      n++;
    end
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout actual=%0d_left required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: pops the scoreboard on every handshake and checks the hold rule.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", {31'd0, valid_out}, 32'd1);
        check("hold_data", {22'd0, shade_out, sof, eol}, {22'd0, prev_shade, prev_sof, prev_eol});
      end
      if (valid_out && ready_in) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out actual=%0h required=none", shade_out);
        end else begin
          e = exp_q.pop_front();
          check("pixel", {22'd0, shade_out, sof, eol}, {22'd0, e.shade, e.sof, e.eol});
          n_out++;
        end
      end
      prev_stall = valid_out && !ready_in && !frame_restart;
      prev_shade = shade_out;
      prev_sof   = sof;
      prev_eol   = eol;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, guard;
    rst = 1'b1;
    frame_restart = 1'b0;
    ready_in = 1'b0;
    lane_valid_in = '0;
    lane_shade_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, valid_out}, 32'd0);
    check("rst_sof", {31'd0, sof}, 32'd0);
    check("rst_eol", {31'd0, eol}, 32'd0);
    check("rst_shade", {24'd0, shade_out}, 32'd0);
    check("rst_ready", {30'd0, lane_ready_out}, 32'd3);
    rst = 1'b0;

    // Ordering: lane1 fills first, output must wait for lane0.
    ready_in = 1'b1;
    hold0 = 1'b1;
    for (int p = 0; p < 8; p++) push_pix(8'(p * 8'h11));
    repeat (6) cycle();
    check("lane1_full_ready", {30'd0, lane_ready_out}, 32'd1);
    check("strict_order_wait", {31'd0, valid_out}, 32'd0);
    hold0 = 1'b0;
    drain();

    // Backpressure: both lanes stream while downstream stalls.
    ready_in = 1'b0;
    for (int p = 0; p < 16; p++) push_pix(8'(8'h80 + p));
    repeat (10) cycle();
    check("bp_ready_low", {30'd0, lane_ready_out}, 32'd0);
    check("bp_valid_held", {31'd0, valid_out}, 32'd1);
    check("bp_first_pixel", {24'd0, shade_out}, 32'h80);
    ready_in = 1'b1;
    drain();

    // Frame wrap: two full frames back to back.
    for (int p = 0; p < 16; p++) push_pix(8'(8'h40 + 3 * p));
    drain();
`ifdef STREAMER_STATS_EN
    check("frame_count", {16'd0, frame_count}, 32'd5);
`endif

    // frame_restart mid-line with FIFOs partly full.
    for (int p = 0; p < 8; p++) push_pix(8'(8'hD0 + p));
    n0 = n_out;
    guard = 0;
    while (n_out - n0 < 3 && guard < 50) begin
      cycle();
      guard++;
    end
    check("restart_setup", n_out - n0, 32'd3);
    ready_in = 1'b0;
    frame_restart = 1'b1;
    lq0.delete();
    lq1.delete();
    lq0.push_back(8'hEE);
    cycle();
    frame_restart = 1'b0;
    lq0.delete();
    exp_q.delete();
    pix_idx = 0;
    check("restart_valid", {31'd0, valid_out}, 32'd0);
    check("restart_sof", {31'd0, sof}, 32'd0);
    check("restart_ready", {30'd0, lane_ready_out}, 32'd3);
    ready_in = 1'b1;
    push_pix(8'hA0);
    push_pix(8'hA1);
    drain();

    // Async reset while stalled.
    ready_in = 1'b0;
    push_pix(8'h5B);
    guard = 0;
    while (!valid_out && guard < 20) begin
      cycle();
      guard++;
    end
    check("pre_reset_valid", {31'd0, valid_out}, 32'd1);
    cycle();
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", {31'd0, valid_out}, 32'd0);
    check("arst_shade", {24'd0, shade_out}, 32'd0);
    check("arst_sof_eol", {30'd0, sof, eol}, 32'd0);
    check("arst_ready", {30'd0, lane_ready_out}, 32'd3);
`ifdef STREAMER_STATS_EN
    check("arst_stall_count", stall_count, 32'd0);
    check("arst_frame_count", {16'd0, frame_count}, 32'd0);
`endif
    exp_q.delete();
    lq0.delete();
    lq1.delete();
    lane_valid_in = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
